// File: rtl/sipo_word_assembler_pkg.sv
// Shared definitions for the serial-to-parallel word assembler and its helpers.
package sipo_word_assembler_pkg;

  // FSM state encoding.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;

  // Bits needed to count 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for serial stages: clear, load-one and increment controls, with a
// terminal flag raised while the count sits at WIDTH-1 (the next capture is the last).
module sipo_bit_counter
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = count_width(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic load1_i,
  input  logic inc_i,
  output logic term_o
);

  logic [CW-1:0] count_q, count_d;

  // Next count: load-one wins over clear, clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (load1_i) begin
      count_d = CW'(1);
    end else if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_word_assembler.sv
// Assembles a WIDTH-bit word from a framed serial stream. Publishes the word with a
// one-cycle load strobe on completion and raises a sticky flag when a frame is aborted.
module sipo_word_assembler
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out,
  output logic             str,
  output logic             busy,
  output logic             frame_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] out_q, out_d;
  logic             str_q, str_d;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_load1, cnt_inc, cnt_term;

  // Shift register contents after capturing sin. Stale bits from an aborted or
  // completed frame need no clearing: exactly WIDTH shifts push them out.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_q[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign shifted = {sin, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .term_o  (cnt_term)
  );

  // Next-state logic: frame start, bit capture, completion and abort.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    out_d     = out_q;
    str_d     = 1'b0;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;

    // In IDLE a valid bit is only taken when it arrives with the frame marker.
    if (sin_valid && ((state_q == S_SHIFT) || frame_start)) begin
      shreg_d = shifted;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d   = S_SHIFT;
          cnt_clr   = 1'b1;
          cnt_load1 = sin_valid;
        end
      end
      S_SHIFT: begin
        if (sin_valid && cnt_term) begin
          // Last bit: publish; a coincident frame marker opens an empty new frame.
          out_d   = shifted;
          str_d   = 1'b1;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = frame_start ? S_SHIFT : S_IDLE;
        end else if (frame_start) begin
          // Abort: drop the partial word and restart, keeping a same-edge bit as bit 0.
          err_d     = 1'b1;
          cnt_clr   = 1'b1;
          cnt_load1 = sin_valid;
        end else if (sin_valid) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      out_q   <= '0;
      str_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      str_q   <= str_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign str       = str_q;
  assign busy      = (state_q == S_SHIFT);
  assign frame_err = err_q;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: one MSB-first and one LSB-first instance share stimulus;
// directed table, hand sequences and random traffic are checked against a frame-level model.
module tb_sipo_word_assembler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sin, sin_valid, frame_start;
  logic [W-1:0] out_m, out_l;
  logic         str_m, str_l, busy_m, busy_l, err_m, err_l;

  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .out(out_m), .str(str_m), .busy(busy_m), .frame_err(err_m)
  );

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .out(out_l), .str(str_l), .busy(busy_l), .frame_err(err_l)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: frame state as a list of received bits.
  bit           m_in_frame;
  bit           m_bits[$];
  logic [W-1:0] m_out_m, m_out_l;
  bit           m_str, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_bits.delete();
    m_out_m = '0;
    m_out_l = '0;
    m_str = 1'b0;
    m_err = 1'b0;
  endtask

  // One clock edge of the framing rules.
  task automatic model_edge(input bit fs, input bit v, input bit b);
    m_str = 1'b0;
    if (!m_in_frame) begin
      if (fs) begin
        m_in_frame = 1'b1;
        m_bits.delete();
        if (v) m_bits.push_back(b);
      end
    end else if (v && m_bits.size() == W - 1) begin
      m_bits.push_back(b);
      m_out_m = '0;
      m_out_l = '0;
      for (int i = 0; i < W; i++) begin
        m_out_m[W-1-i] = m_bits[i];
        m_out_l[i]     = m_bits[i];
      end
      m_str = 1'b1;
      m_err = 1'b0;
      m_bits.delete();
      m_in_frame = fs;
    end else if (fs) begin
      m_err = 1'b1;
      m_bits.delete();
      if (v) m_bits.push_back(b);
    end else if (v) begin
      m_bits.push_back(b);
    end
  endtask

  task automatic compare_all();
    check("out_msb",   32'(out_m),  32'(m_out_m));
    check("out_lsb",   32'(out_l),  32'(m_out_l));
    check("str_msb",   32'(str_m),  32'(m_str));
    check("str_lsb",   32'(str_l),  32'(m_str));
    check("busy_msb",  32'(busy_m), 32'(m_in_frame));
    check("busy_lsb",  32'(busy_l), 32'(m_in_frame));
    check("ferr_msb",  32'(err_m),  32'(m_err));
    check("ferr_lsb",  32'(err_l),  32'(m_err));
  endtask

  task automatic step(input bit fs, input bit v, input bit b);
    @(negedge clk);
    frame_start = fs;
    sin_valid   = v;
    sin         = b;
    @(posedge clk);
    #1;
    model_edge(fs, v, b);
    compare_all();
  endtask

  // Send a word MSB-of-w first, with idle gaps between bits.
  task automatic send(input logic [W-1:0] w, input int gap, input bit first_fs, input bit last_fs);
    for (int i = W - 1; i >= 0; i--) begin
      if (i != W - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
      step((i == W - 1) ? first_fs : ((i == 0) ? last_fs : 1'b0), 1'b1, w[i]);
    end
  endtask

  typedef struct {
    bit           fs, v, b;
    bit           e_busy, e_str;
    logic [W-1:0] e_out_m, e_out_l;
  } vec_t;

  vec_t         tbl[9];
  logic [W-1:0] pat;

  initial begin
    // Directed 0xA5 frame, first bit with the frame marker, no gaps, then one idle edge.
    pat = 8'hA5;
    for (int i = 0; i < W; i++) begin
      tbl[i] = '{fs: (i == 0), v: 1'b1, b: pat[W-1-i], e_busy: (i != W - 1), e_str: (i == W - 1),
                 e_out_m: (i == W - 1) ? 8'hA5 : 8'h00, e_out_l: (i == W - 1) ? 8'hA5 : 8'h00};
    end
    tbl[8] = '{fs: 1'b0, v: 1'b0, b: 1'b0, e_busy: 1'b0, e_str: 1'b0, e_out_m: 8'hA5, e_out_l: 8'hA5};

    reset = 1'b1;
    sin = 1'b0;
    sin_valid = 1'b0;
    frame_start = 1'b0;
    model_reset();
    #2;
    check("rst_out", 32'(out_m), 32'h0);
    check("rst_str", 32'(str_m), 32'h0);
    check("rst_busy", 32'(busy_m), 32'h0);
    check("rst_ferr", 32'(err_m), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].fs, tbl[i].v, tbl[i].b);
      $display("vec %0d fs=%0b v=%0b b=%0b -> out_m=%02h str=%0b busy=%0b",
               i, tbl[i].fs, tbl[i].v, tbl[i].b, out_m, str_m, busy_m);
      check("tbl_busy", 32'(busy_m), 32'(tbl[i].e_busy));
      check("tbl_str", 32'(str_m), 32'(tbl[i].e_str));
      check("tbl_out_m", 32'(out_m), 32'(tbl[i].e_out_m));
      check("tbl_out_l", 32'(out_l), 32'(tbl[i].e_out_l));
    end

    // Gapped frames: palindrome 0xA5, then 1,1,0,0,0,0,0,0.
    send(8'hA5, 2, 1'b1, 1'b0);
    $display("gap frame A5 -> out_m=%02h out_l=%02h", out_m, out_l);
    check("gap_a5_m", 32'(out_m), 32'hA5);
    check("gap_a5_l", 32'(out_l), 32'hA5);
    check("gap_a5_str", 32'(str_l), 32'h1);
    send(8'hC0, 2, 1'b1, 1'b0);
    $display("gap frame C0 -> out_m=%02h out_l=%02h", out_m, out_l);
    check("gap_c0_m", 32'(out_m), 32'hC0);
    check("gap_c0_l", 32'(out_l), 32'h03);

    // Abort after 5 bits, then a full 0x3C frame in the restarted frame.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'(i & 1));
    step(1'b1, 1'b0, 1'b0);
    $display("abort -> ferr=%0b out_m=%02h str=%0b", err_m, out_m, str_m);
    check("abort_ferr", 32'(err_m), 32'h1);
    check("abort_out", 32'(out_m), 32'hC0);
    check("abort_str", 32'(str_m), 32'h0);
    send(8'h3C, 0, 1'b0, 1'b0);
    $display("post-abort frame -> out_m=%02h ferr=%0b str=%0b", out_m, err_m, str_m);
    check("abort_done_out", 32'(out_m), 32'h3C);
    check("abort_done_ferr", 32'(err_m), 32'h0);
    check("abort_done_str", 32'(str_m), 32'h1);

    // Back-to-back: frame marker on the last bit of 0xFF, then 0x00.
    send(8'hFF, 0, 1'b1, 1'b1);
    $display("b2b first -> out_m=%02h str=%0b busy=%0b", out_m, str_m, busy_m);
    check("b2b_ff_out", 32'(out_m), 32'hFF);
    check("b2b_ff_busy", 32'(busy_m), 32'h1);
    check("b2b_ff_ferr", 32'(err_m), 32'h0);
    send(8'h00, 0, 1'b0, 1'b0);
    $display("b2b second -> out_m=%02h str=%0b busy=%0b", out_m, str_m, busy_m);
    check("b2b_00_out", 32'(out_m), 32'h00);
    check("b2b_00_str", 32'(str_m), 32'h1);
    check("b2b_00_ferr", 32'(err_m), 32'h0);

    // Idle noise: valid toggles without a frame marker.
    send(8'h5A, 0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'(i & 1), 1'($urandom_range(0, 1)));
    $display("idle noise -> out_m=%02h busy=%0b", out_m, busy_m);
    check("idle_out", 32'(out_m), 32'h5A);
    check("idle_busy", 32'(busy_m), 32'h0);

    // Asynchronous reset 3 bits into a frame, away from any clock edge.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    sin_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("mid-frame reset -> out_m=%02h str=%0b busy=%0b ferr=%0b", out_m, str_m, busy_m, err_m);
    check("mrst_out", 32'(out_m), 32'h0);
    check("mrst_out_l", 32'(out_l), 32'h0);
    check("mrst_busy", 32'(busy_m), 32'h0);
    check("mrst_str", 32'(str_m), 32'h0);
    check("mrst_ferr", 32'(err_m), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send(8'hA5, 0, 1'b1, 1'b0);
    $display("post-reset frame -> out_m=%02h str=%0b", out_m, str_m);
    check("mrst_a5", 32'(out_m), 32'hA5);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_str) $display("rand edge %0d: word out_m=%02h out_l=%02h", i, out_m, out_l);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
